fpm_sched: RTL and testbench

Round-robin scheduler that shares one single-precision floating-point multiply datapath between NREQ requesters. It sits between the requesting blocks and the combinational FP multiplier: it grants one operand pair per cycle, registers the operands into the multiplier, and pipelines the product with the requester tag. Results are buffered in an output FIFO with valid/ready backpressure. Issue is credit-limited, so no product is ever dropped.

---
 rtl/fpm_sched_if.sv | 31 +++
 rtl/fpm_sched.sv | 187 ++++++++++++++++++
 tb/tb_fpm_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpm_sched_if.sv
// fpm_sched_if: requester, multiplier and response signals of the FP multiply
// scheduler. The slave modport is the scheduler's view; master is the
// environment's view (requesters, multiplier and consumer together).
interface fpm_sched_if #(
  parameter int NREQ = 4
) ();
  localparam int TW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          mul_a;
  logic [31:0]          mul_b;
  logic [31:0]          mul_p;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_data;
  logic [TW-1:0]        resp_tag;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, resp_ready,
    output req_ready, mul_a, mul_b, resp_valid, resp_data, resp_tag, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, resp_ready,
    input  req_ready, mul_a, mul_b, resp_valid, resp_data, resp_tag, busy
  );
endinterface

// File: rtl/fpm_sched.sv
// fpm_sched: round-robin scheduler sharing one combinational FP multiplier
// between NREQ requesters. Operands are registered into the multiplier, the
// product is pipelined with its requester tag and buffered in an output FIFO.
// Issue is credit-limited (in-flight + buffered < DEPTH) so nothing is dropped.
// Optional build macro FPM_SCHED_PRIO0_EN: requester 0 gets strict priority and
// requesters 1..NREQ-1 round-robin among themselves.
module fpm_sched #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  fpm_sched_if.slave bus
);
  localparam int TW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TW-1:0]   last_q, last_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [LAT-1:0]  v_q, v_d;
  logic [TW-1:0]   tag_q [LAT];
  logic [TW-1:0]   tag_d [LAT];
  logic [31:0]     pr_q [LAT];
  logic [31:0]     pr_d [LAT];
  logic [31:0]     mem_dat_q [DEPTH];
  logic [31:0]     mem_dat_d [DEPTH];
  logic [TW-1:0]   mem_tag_q [DEPTH];
  logic [TW-1:0]   mem_tag_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic [TW-1:0]   resp_tag_q, resp_tag_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic [TW-1:0]   gidx;
  logic            found;
  logic            accept;
  logic            issue_ok;
  logic            push;
  logic            pop;
  logic [31:0]     push_dat;
  logic [TW-1:0]   push_tag;
  int unsigned     occ;

  // Credit: stage valids plus buffered entries must leave room in the FIFO.
  always_comb begin
    occ = 32'(cnt_q);
    for (int k = 0; k < LAT; k++) begin
      occ = occ + 32'(v_q[k]);
    end
    issue_ok = (occ < 32'(DEPTH));
  end

  // Arbitration: first valid requester after `last`, gated by credit and reset.
  always_comb begin
    int  idx;
    logic hit;
    idx   = 0;
    hit   = 1'b0;
    found = 1'b0;
    gidx  = {TW{1'b0}};
`ifdef FPM_SCHED_PRIO0_EN
    if (bus.req_valid[0]) begin
      found = 1'b1;
      gidx  = {TW{1'b0}};
    end else begin
      for (int i = 1; i < NREQ; i++) begin
        idx   = ((int'(last_q) - 1 + i) % (NREQ - 1)) + 1;
        hit   = !found && bus.req_valid[idx[TW-1:0]];
        gidx  = hit ? idx[TW-1:0] : gidx;
        found = found | hit;
      end
    end
`else
    for (int i = 1; i <= NREQ; i++) begin
      idx   = (int'(last_q) + i) % NREQ;
      hit   = !found && bus.req_valid[idx[TW-1:0]];
      gidx  = hit ? idx[TW-1:0] : gidx;
      found = found | hit;
    end
`endif
    accept = rst_n && issue_ok && found;
    grant  = accept ? (NREQ'(1'b1) << gidx) : {NREQ{1'b0}};
`ifdef FPM_SCHED_PRIO0_EN
    last_d = (accept && (gidx != {TW{1'b0}})) ? gidx : last_q;
`else
    last_d = accept ? gidx : last_q;
`endif
    mul_a_d = accept ? bus.req_a[{gidx, 5'd0} +: 32] : mul_a_q;
    mul_b_d = accept ? bus.req_b[{gidx, 5'd0} +: 32] : mul_b_q;
  end

  // Product/tag pipeline and output FIFO next-state, including registered head.
  always_comb begin
    v_d      = {LAT{1'b0}};
    v_d[0]   = accept;
    tag_d[0] = gidx;
    pr_d[0]  = 32'h0000_0000;
    for (int k = 1; k < LAT; k++) begin
      v_d[k]   = v_q[k-1];
      tag_d[k] = tag_q[k-1];
      pr_d[k]  = (k == 1) ? bus.mul_p : pr_q[k-1];
    end

    push     = v_q[LAT-1];
    push_tag = tag_q[LAT-1];
    push_dat = (LAT == 1) ? bus.mul_p : pr_q[LAT-1];
    pop      = resp_valid_q && bus.resp_ready;

    mem_dat_d = mem_dat_q;
    mem_tag_d = mem_tag_q;
    if (push) begin
      mem_dat_d[wptr_q] = push_dat;
      mem_tag_d[wptr_q] = push_tag;
      wptr_d            = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    rptr_d = pop ? (rptr_q + AW'(1)) : rptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    resp_valid_d = (cnt_d != {CW{1'b0}});
    resp_data_d  = resp_valid_d ? mem_dat_d[rptr_d] : 32'h0000_0000;
    resp_tag_d   = resp_valid_d ? mem_tag_d[rptr_d] : {TW{1'b0}};
    busy_d       = (v_d != {LAT{1'b0}}) || (cnt_d != {CW{1'b0}});
  end

  // State registers; synchronous reset discards everything in flight or buffered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q       <= TW'(NREQ - 1);
      mul_a_q      <= 32'h0000_0000;
      mul_b_q      <= 32'h0000_0000;
      v_q          <= {LAT{1'b0}};
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= {TW{1'b0}};
        pr_q[k]  <= 32'h0000_0000;
      end
      for (int e = 0; e < DEPTH; e++) begin
        mem_dat_q[e] <= 32'h0000_0000;
        mem_tag_q[e] <= {TW{1'b0}};
      end
      wptr_q       <= {AW{1'b0}};
      rptr_q       <= {AW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
      resp_tag_q   <= {TW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      last_q       <= last_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      v_q          <= v_d;
      tag_q        <= tag_d;
      pr_q         <= pr_d;
      mem_dat_q    <= mem_dat_d;
      mem_tag_q    <= mem_tag_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fpm_sched.sv
// tb_fpm_sched: directed bench for fpm_sched (NREQ=4, LAT=2, DEPTH=4) with a
// table-driven stand-in multiplier and an in-order expected-result queue.
module tb_fpm_sched;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpm_sched_if #(.NREQ(NREQ)) bus_if ();

  fpm_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total  = 0;
  int passed = 0;
  int nfail  = 0;
  int acc_cnt = 0;
  logic [31:0] exp_dat [$];
  int          exp_tag [$];
  logic [NREQ-1:0] exp_g;

  // Stand-in multiplier: hand-computed products for the directed operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0000_0000 || b == 32'h0000_0000) return 32'h0000_0000;
    else if (a == 32'h4000_0000 && b == 32'h4080_0000) return 32'h4100_0000;
    else if (a == 32'h411C_0000 && b == 32'h3F10_0000) return 32'h40AF_8000;
    else if (a == 32'h7F80_0000 && b == 32'h7380_0000) return 32'h7F80_0000;
    else return a ^ {b[15:0], b[31:16]};
  endfunction

  // Combinational multiplier model feeding the scheduler.
  always_comb bus_if.mul_p = fmul(bus_if.mul_a, bus_if.mul_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: check any pop against the queue, record any accept, then advance.
  task automatic step();
    int gi;
    #1;
    if (bus_if.resp_valid === 1'b1 && bus_if.resp_ready === 1'b1) begin
      total++;
      assert (exp_dat.size() != 0) passed++;
      else begin
        nfail++;
        $error("FAIL resp_pending: response %h observed with no expected result", bus_if.resp_data);
      end
      if (exp_dat.size() != 0) begin
        chk("resp_data", bus_if.resp_data, exp_dat.pop_front());
        chk("resp_tag", 32'(bus_if.resp_tag), 32'(exp_tag.pop_front()));
      end
    end
    gi = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (bus_if.req_ready[i] === 1'b1) gi = i;
    end
    if (gi >= 0) begin
      exp_dat.push_back(fmul(bus_if.req_a[32*gi +: 32], bus_if.req_b[32*gi +: 32]));
      exp_tag.push_back(gi);
      acc_cnt++;
    end
    chk("no_overflow", 32'(exp_dat.size() <= DEPTH), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus_if.req_valid  = 4'b0000;
    bus_if.resp_ready = 1'b1;
    for (int n = 0; n < 30 && exp_dat.size() != 0; n++) step();
    chk("drain_empty", 32'(exp_dat.size()), 32'd0);
    chk("drain_busy", 32'(bus_if.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus_if.req_valid  = 4'b0000;
    bus_if.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_dat.delete();
    exp_tag.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus_if.req_valid  = 4'b0000;
    bus_if.req_a      = '0;
    bus_if.req_b      = '0;
    bus_if.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with all requesters valid to confirm req_ready is gated.
    bus_if.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_mul_a", bus_if.mul_a, 32'h0000_0000);
    chk("rst_mul_b", bus_if.mul_b, 32'h0000_0000);
    chk("rst_resp_data", bus_if.resp_data, 32'h0000_0000);
    chk("rst_resp_tag", 32'(bus_if.resp_tag), 32'd0);
    bus_if.req_valid = 4'b0000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request: requester 2, 2.0 x 4.0.
    bus_if.req_a[64 +: 32] = 32'h4000_0000;
    bus_if.req_b[64 +: 32] = 32'h4080_0000;
    bus_if.req_valid       = 4'b0100;
    #1;
    chk("single_grant", 32'(bus_if.req_ready), 32'(4'b0100));
    step();
    bus_if.req_valid = 4'b0000;
    chk("single_mul_a", bus_if.mul_a, 32'h4000_0000);
    chk("single_mul_b", bus_if.mul_b, 32'h4080_0000);
    step();
    chk("single_not_yet", 32'(bus_if.resp_valid), 32'd0);
    chk("single_busy", 32'(bus_if.busy), 32'd1);
    step();
    chk("single_valid", 32'(bus_if.resp_valid), 32'd1);
    chk("single_data", bus_if.resp_data, 32'h4100_0000);
    chk("single_tag", 32'(bus_if.resp_tag), 32'd2);
    bus_if.resp_ready = 1'b1;
    step();
    chk("single_popped", 32'(bus_if.resp_valid), 32'd0);
    chk("single_idle", 32'(bus_if.busy), 32'd0);

    // All-valid round-robin from reset with the consumer always ready.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus_if.req_a[32*i +: 32] = 32'h3F80_0000 | 32'(i << 4);
      bus_if.req_b[32*i +: 32] = 32'h4000_0000 | 32'(i);
    end
    bus_if.req_valid  = 4'b1111;
    bus_if.resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef FPM_SCHED_PRIO0_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % NREQ);
`endif
      chk("rr_grant", 32'(bus_if.req_ready), 32'(exp_g));
      step();
      if (k >= LAT) chk("rr_stream_valid", 32'(bus_if.resp_valid), 32'd1);
    end
    drain();

    // Backpressure: consumer stalled, every requester issues 9.75 x 0.5625.
    for (int i = 0; i < NREQ; i++) begin
      bus_if.req_a[32*i +: 32] = 32'h411C_0000;
      bus_if.req_b[32*i +: 32] = 32'h3F10_0000;
    end
    bus_if.resp_ready = 1'b0;
    bus_if.req_valid  = 4'b1111;
    acc_cnt = 0;
    repeat (8) step();
    chk("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
    #1;
    chk("stall_ready_low", 32'(bus_if.req_ready), 32'd0);
    chk("stall_head", bus_if.resp_data, 32'h40AF_8000);
    bus_if.resp_ready = 1'b1;
    #1;
    chk("pop_cycle_no_credit", 32'(bus_if.req_ready), 32'd0);
    step();
    bus_if.resp_ready = 1'b0;
    #1;
    chk("credit_returned", 32'(|bus_if.req_ready), 32'd1);
    acc_cnt = 0;
    step();
    chk("one_more_accept", 32'(acc_cnt), 32'd1);
    #1;
    chk("full_again", 32'(bus_if.req_ready), 32'd0);

    // Full FIFO with simultaneous push and pop: stream while consumer ready.
    step();
    bus_if.resp_ready = 1'b1;
    repeat (10) step();
    chk("stream_head", bus_if.resp_data, 32'h40AF_8000);
    drain();

    // Special operands: infinity and zero pass through unchanged.
    bus_if.resp_ready      = 1'b0;
    bus_if.req_a[32 +: 32] = 32'h7F80_0000;
    bus_if.req_b[32 +: 32] = 32'h7380_0000;
    bus_if.req_valid       = 4'b0010;
    step();
    bus_if.req_valid = 4'b0000;
    step();
    step();
    chk("inf_data", bus_if.resp_data, 32'h7F80_0000);
    chk("inf_tag", 32'(bus_if.resp_tag), 32'd1);
    drain();
    bus_if.resp_ready      = 1'b0;
    bus_if.req_a[96 +: 32] = 32'h0000_0000;
    bus_if.req_b[96 +: 32] = 32'h4040_0000;
    bus_if.req_valid       = 4'b1000;
    step();
    bus_if.req_valid = 4'b0000;
    step();
    step();
    chk("zero_valid", 32'(bus_if.resp_valid), 32'd1);
    chk("zero_data", bus_if.resp_data, 32'h0000_0000);
    chk("zero_tag", 32'(bus_if.resp_tag), 32'd3);
    drain();

    // Reset mid-operation: two in flight, two buffered.
    bus_if.resp_ready = 1'b0;
    bus_if.req_valid  = 4'b1111;
    repeat (4) step();
    chk("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    chk("pre_rst_valid", 32'(bus_if.resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus_if.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    exp_dat.delete();
    exp_tag.delete();
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(bus_if.req_ready), 32'(4'b0001));
    step();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
